// File: rtl/transport_pkg.sv
// transport_pkg: shared header constants, parser states, record type and header decode helper.
// Build option: TRANSPORT_RX_CHECKSUM_EN adds the S_CHECK parser state.
package transport_pkg;
  localparam logic [5:0] HDR_CTRL_PREFIX = 6'b01_0000;
  localparam logic [7:0] HDR_AUDIO = 8'b1000_0000;
  localparam int DATA_MAX_W = 64;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PHONE,
    S_PAYLOAD,
    S_DISCARD
`ifdef TRANSPORT_RX_CHECKSUM_EN
    , S_CHECK
`endif
  } rx_state_e;
  typedef struct packed {
    logic pkt_type;
    logic [1:0] cmd;
    logic [7:0] phone;
    logic [DATA_MAX_W-1:0] data;
  } rx_rec_t;
  function automatic logic hdr_ok(input logic [7:0] h);
    return (h[7:2] == HDR_CTRL_PREFIX) || (h == HDR_AUDIO);
  endfunction
endpackage

// File: rtl/transport_packet_rx_if.sv
// transport_packet_rx_if: byte input stream and parsed-record valid/ready output.
// Ports: in_valid/in_sop/in_data byte strobe, out_ready/out_valid handshake with out_type/out_cmd/out_phone/out_data.
// master drives the bytes and consumes records; slave is the parser.
interface transport_packet_rx_if #(parameter int DATA_W = 16);
  logic in_valid;
  logic in_sop;
  logic [7:0] in_data;
  logic out_ready;
  logic out_valid;
  logic out_type;
  logic [1:0] out_cmd;
  logic [7:0] out_phone;
  logic [DATA_W-1:0] out_data;
  modport master (output in_valid, in_sop, in_data, out_ready,
                  input out_valid, out_type, out_cmd, out_phone, out_data);
  modport slave (input in_valid, in_sop, in_data, out_ready,
                 output out_valid, out_type, out_cmd, out_phone, out_data);
endinterface

// File: rtl/transport_rx_fifo.sv
// transport_rx_fifo: synchronous first-word-fall-through FIFO for parsed records.
// Ports: clk, reset (async, active-high), wr_en/wr_data push, rd_en/rd_data pop, empty, full.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module transport_rx_fifo #(
  parameter int W = 27,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign rd_data = mem[rd_ptr_q];
  always_comb begin
    pop = rd_en && !empty;
    push = wr_en && (!full || rd_en);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr_q] <= wr_data;
endmodule

// File: rtl/transport_packet_rx.sv
// transport_packet_rx: parses header/phone/payload byte packets into records queued for the session layer.
// Ports: clk, reset (async, active-high), bus (transport_packet_rx_if.slave), busy, err_pulse, drop_count.
// Build option: TRANSPORT_RX_CHECKSUM_EN expects a trailing XOR checksum byte after the payload.
module transport_packet_rx
  import transport_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PHONE_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  transport_packet_rx_if.slave        bus,
  output logic                        busy,
  output logic                        err_pulse,
  output logic [7:0]                  drop_count
);
  localparam int NB = DATA_W / 8;
  localparam int RW = 3 + PHONE_W + DATA_W;
  rx_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic pkt_type_q, pkt_type_d;
  logic [1:0] cmd_q, cmd_d;
  logic [PHONE_W-1:0] phone_q, phone_d;
  logic [DATA_W-1:0] data_q, data_d;
`ifdef TRANSPORT_RX_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  logic err_pulse_q, err_pulse_d;
  logic [7:0] drop_count_q, drop_count_d;
  logic [8:0] drop_sum;
  logic [1:0] drops;
  logic commit, partial, pop;
  rx_rec_t rec;
  logic [RW-1:0] rd_data;
  logic fifo_empty, fifo_full;
  assign busy = state_q != S_IDLE;
  assign err_pulse = err_pulse_q;
  assign drop_count = drop_count_q;
  assign bus.out_valid = !fifo_empty;
  assign pop = bus.out_valid && bus.out_ready;
  assign bus.out_type = bus.out_valid && rd_data[RW-1];
  assign bus.out_cmd = bus.out_valid ? rd_data[RW-2 -: 2] : 2'b00;
  assign bus.out_phone = bus.out_valid ? rd_data[DATA_W +: PHONE_W] : '0;
  assign bus.out_data = bus.out_valid ? rd_data[DATA_W-1:0] : '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pkt_type_d = pkt_type_q;
    cmd_d = cmd_q;
    phone_d = phone_q;
    data_d = data_q;
`ifdef TRANSPORT_RX_CHECKSUM_EN
    csum_d = csum_q;
`endif
    commit = 1'b0;
    drops = 2'd0;
    partial = state_q != S_IDLE && state_q != S_DISCARD;
    if (bus.in_valid && bus.in_sop) begin
      // A new header always wins: abandon any partial packet and decode this byte.
      drops = 2'(partial) + 2'(!hdr_ok(bus.in_data));
      state_d = hdr_ok(bus.in_data) ? S_PHONE : S_DISCARD;
      pkt_type_d = bus.in_data[7];
      cmd_d = bus.in_data[7] ? 2'b00 : bus.in_data[1:0];
`ifdef TRANSPORT_RX_CHECKSUM_EN
      csum_d = bus.in_data;
`endif
    end else if (bus.in_valid) begin
`ifdef TRANSPORT_RX_CHECKSUM_EN
      csum_d = csum_q ^ bus.in_data;
`endif
      case (state_q)
        S_PHONE: begin
          phone_d = PHONE_W'(bus.in_data);
          cnt_d = 3'(NB - 1);
          state_d = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          data_d = DATA_W'({data_q, bus.in_data});
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
`ifdef TRANSPORT_RX_CHECKSUM_EN
            state_d = S_CHECK;
`else
            commit = 1'b1;
            state_d = S_IDLE;
`endif
          end
        end
`ifdef TRANSPORT_RX_CHECKSUM_EN
        S_CHECK: begin
          commit = bus.in_data == csum_q;
          drops = 2'(!commit);
          state_d = S_IDLE;
        end
`endif
        default: ;
      endcase
    end
    // The FIFO refuses a push when full unless the head leaves in the same cycle.
    if (commit && fifo_full && !bus.out_ready) drops = 2'd1;
    rec = '{pkt_type: pkt_type_q, cmd: cmd_q, phone: 8'(phone_q), data: DATA_MAX_W'(data_d)};
    err_pulse_d = drops != 2'd0;
    drop_sum = {1'b0, drop_count_q} + 9'(drops);
    drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      pkt_type_q <= 1'b0;
      cmd_q <= '0;
      phone_q <= '0;
      data_q <= '0;
`ifdef TRANSPORT_RX_CHECKSUM_EN
      csum_q <= '0;
`endif
      err_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pkt_type_q <= pkt_type_d;
      cmd_q <= cmd_d;
      phone_q <= phone_d;
      data_q <= data_d;
`ifdef TRANSPORT_RX_CHECKSUM_EN
      csum_q <= csum_d;
`endif
      err_pulse_q <= err_pulse_d;
      drop_count_q <= drop_count_d;
    end
  transport_rx_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(commit),
    .wr_data({rec.pkt_type, rec.cmd, PHONE_W'(rec.phone), DATA_W'(rec.data)}),
    .rd_en(bus.out_ready),
    .rd_data(rd_data),
    .empty(fifo_empty),
    .full(fifo_full)
  );
endmodule

// File: tb/tb_transport_packet_rx.sv
// tb_transport_packet_rx: directed self-checking bench for transport_packet_rx.
module tb_transport_packet_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, err_pulse;
  logic [7:0] drop_count;
  logic [7:0] ph;
  int checks = 0;
  int errors = 0;
  transport_packet_rx_if #(.DATA_W(16)) bus ();
  transport_packet_rx #(.DATA_W(16), .FIFO_DEPTH(8), .PHONE_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .err_pulse(err_pulse),
    .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic s, input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_sop = s;
    bus.in_data = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask
  task automatic send_pkt(input logic [7:0] h, input logic [7:0] p, input logic [15:0] d, input logic rdy_last);
    beat(1'b1, h);
    beat(1'b0, p);
    beat(1'b0, d[15:8]);
`ifdef TRANSPORT_RX_CHECKSUM_EN
    beat(1'b0, d[7:0]);
    bus.out_ready = rdy_last;
    beat(1'b0, h ^ p ^ d[15:8] ^ d[7:0]);
`else
    bus.out_ready = rdy_last;
    beat(1'b0, d[7:0]);
`endif
    bus.out_ready = 1'b0;
  endtask
  task automatic check_rec(input logic t, input logic [1:0] c, input logic [7:0] p, input logic [15:0] d);
    chk("rec_valid", 32'(bus.out_valid), 32'd1);
    chk("rec_type", 32'(bus.out_type), 32'(t));
    chk("rec_cmd", 32'(bus.out_cmd), 32'(c));
    chk("rec_phone", 32'(bus.out_phone), 32'(p));
    chk("rec_data", 32'(bus.out_data), 32'(d));
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    beat(1'b1, 8'h41);
    chk("busy_hdr", 32'(busy), 32'd1);
    beat(1'b0, 8'h07);
    beat(1'b0, 8'hAB);
`ifdef TRANSPORT_RX_CHECKSUM_EN
    beat(1'b0, 8'hCD);
    chk("ck_wait_valid", 32'(bus.out_valid), 32'd0);
    beat(1'b0, 8'h20);
`else
    beat(1'b0, 8'hCD);
`endif
    check_rec(1'b0, 2'b01, 8'h07, 16'hABCD);
    chk("ctrl_busy", 32'(busy), 32'd0);
    chk("ctrl_err", 32'(err_pulse), 32'd0);
    pop();
    chk("ctrl_popped", 32'(bus.out_valid), 32'd0);
    send_pkt(8'h80, 8'h12, 16'h55AA, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_rec(1'b1, 2'b00, 8'h12, 16'h55AA);
      idle(1);
    end
    check_rec(1'b1, 2'b00, 8'h12, 16'h55AA);
    pop();
    chk("audio_popped", 32'(bus.out_valid), 32'd0);
    beat(1'b1, 8'h3F);
    chk("bad_err", 32'(err_pulse), 32'd1);
    chk("bad_drops", 32'(drop_count), 32'd1);
    chk("bad_busy", 32'(busy), 32'd1);
    beat(1'b0, 8'h41);
    chk("bad_err_once", 32'(err_pulse), 32'd0);
    beat(1'b0, 8'h07);
    beat(1'b0, 8'hAB);
    beat(1'b0, 8'hCD);
    beat(1'b0, 8'h20);
    chk("discard_valid", 32'(bus.out_valid), 32'd0);
    chk("discard_busy", 32'(busy), 32'd1);
    chk("discard_drops", 32'(drop_count), 32'd1);
    beat(1'b1, 8'h80);
    beat(1'b0, 8'h33);
    beat(1'b0, 8'h11);
    beat(1'b1, 8'h41);
    chk("cut_err", 32'(err_pulse), 32'd1);
    chk("cut_drops", 32'(drop_count), 32'd2);
    chk("cut_valid", 32'(bus.out_valid), 32'd0);
    beat(1'b0, 8'h05);
    beat(1'b0, 8'hDE);
    beat(1'b0, 8'hAD);
`ifdef TRANSPORT_RX_CHECKSUM_EN
    beat(1'b0, 8'h41 ^ 8'h05 ^ 8'hDE ^ 8'hAD);
`endif
    check_rec(1'b0, 2'b01, 8'h05, 16'hDEAD);
    pop();
    for (int i = 0; i < 9; i++) begin
      send_pkt(8'h80, 8'(i), {8'(i), ~8'(i)}, 1'b0);
      if (i == 7) begin
        chk("fill_err", 32'(err_pulse), 32'd0);
        chk("fill_drops", 32'(drop_count), 32'd2);
      end
    end
    chk("full_err", 32'(err_pulse), 32'd1);
    chk("full_drops", 32'(drop_count), 32'd3);
    send_pkt(8'h80, 8'h0A, 16'h0AF5, 1'b1);
    chk("full_pop_err", 32'(err_pulse), 32'd0);
    chk("full_pop_drops", 32'(drop_count), 32'd3);
    for (int i = 1; i <= 8; i++) begin
      ph = (i == 8) ? 8'h0A : 8'(i);
      check_rec(1'b1, 2'b00, ph, {ph, ~ph});
      pop();
    end
    chk("drained", 32'(bus.out_valid), 32'd0);
`ifdef TRANSPORT_RX_CHECKSUM_EN
    beat(1'b1, 8'h41);
    beat(1'b0, 8'h07);
    beat(1'b0, 8'hAB);
    beat(1'b0, 8'hCD);
    beat(1'b0, 8'h00);
    chk("ck_bad_err", 32'(err_pulse), 32'd1);
    chk("ck_bad_drops", 32'(drop_count), 32'd4);
    chk("ck_bad_valid", 32'(bus.out_valid), 32'd0);
`endif
    repeat (260) beat(1'b1, 8'h3F);
    chk("sat_drops", 32'(drop_count), 32'd255);
    chk("sat_err", 32'(err_pulse), 32'd1);
    idle(1);
    chk("sat_err_end", 32'(err_pulse), 32'd0);
    send_pkt(8'h80, 8'h44, 16'h1234, 1'b0);
    beat(1'b1, 8'h41);
    beat(1'b0, 8'h07);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_drops", 32'(drop_count), 32'd0);
    chk("arst_err", 32'(err_pulse), 32'd0);
    chk("arst_phone", 32'(bus.out_phone), 32'd0);
    chk("arst_data", 32'(bus.out_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    beat(1'b0, 8'hAB);
    beat(1'b0, 8'hCD);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    send_pkt(8'h43, 8'h01, 16'hBEEF, 1'b0);
    check_rec(1'b0, 2'b11, 8'h01, 16'hBEEF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
